// File: rtl/pluck_voice_allocator.sv
// pluck_voice_allocator
// Sequencer/arbiter in front of a bank of plucked-string voices. Each voice
// runs IDLE -> EXCITE (noise burst) -> RING -> IDLE. A note request goes to
// the lowest-index idle voice. If no voice is idle, it takes the oldest ringing
// voice. The chosen voice gets a one-cycle trigger and its length/octave
// configuration is latched.

module pluck_voice_allocator #(
    parameter int NUM_VOICES  = 4,
    parameter int LEN_W       = 10,
    parameter int MIN_LEN     = 4,
    parameter int BURST_SHIFT = 1,
    parameter int RING_CYCLES = 48000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          note_valid,
    output logic                          note_ready,
    input  logic [LEN_W-1:0]              note_len,
    input  logic [1:0]                    note_oct,
    output logic [NUM_VOICES-1:0]         voice_trig,
    output logic [NUM_VOICES*LEN_W-1:0]   voice_len,
    output logic [NUM_VOICES*2-1:0]       voice_oct,
    output logic [NUM_VOICES-1:0]         voice_busy,
    output logic [$clog2(NUM_VOICES)-1:0] alloc_id,
    output logic                          steal
);

    localparam int VID_W   = $clog2(NUM_VOICES);
    localparam int BURST_W = LEN_W + BURST_SHIFT;
    localparam int RING_W  = $clog2(RING_CYCLES + 1);
    // One counter per voice serves both the burst and the ring phase.
    localparam int CNT_W   = (BURST_W > RING_W) ? BURST_W : RING_W;

    localparam logic [VID_W-1:0] AGE_MAX  = {VID_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RING = CNT_W'(RING_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXCITE = 2'd1,
        ST_RING   = 2'd2
    } vstate_e;

    // Length after the octave shift, clamped so very short delay lines
    // still get a usable excitation burst.
    function automatic logic [LEN_W-1:0] calc_eff_len(
        input logic [LEN_W-1:0] len,
        input logic [1:0]       oct
    );
        logic [LEN_W-1:0] shifted;
        shifted = len >> oct;
        if (shifted < LEN_W'(MIN_LEN)) begin
            calc_eff_len = LEN_W'(MIN_LEN);
        end else begin
            calc_eff_len = shifted;
        end
    endfunction

    // State registers.
    vstate_e                     state_q [NUM_VOICES];
    vstate_e                     state_d [NUM_VOICES];
    logic [CNT_W-1:0]            cnt_q   [NUM_VOICES];
    logic [CNT_W-1:0]            cnt_d   [NUM_VOICES];
    logic [VID_W-1:0]            age_q   [NUM_VOICES];
    logic [VID_W-1:0]            age_d   [NUM_VOICES];

    logic [NUM_VOICES-1:0]       voice_trig_q, voice_trig_d;
    logic [NUM_VOICES*LEN_W-1:0] voice_len_q,  voice_len_d;
    logic [NUM_VOICES*2-1:0]     voice_oct_q,  voice_oct_d;
    logic [NUM_VOICES-1:0]       voice_busy_q, voice_busy_d;
    logic [VID_W-1:0]            alloc_id_q,   alloc_id_d;
    logic                        steal_q,      steal_d;

    // Arbitration results.
    logic                        idle_found_s;
    logic [VID_W-1:0]            idle_idx_s;
    logic                        ring_found_s;
    logic [VID_W-1:0]            ring_idx_s;
    logic [VID_W-1:0]            ring_age_s;
    logic [VID_W-1:0]            sel_idx_s;
    logic                        sel_steal_s;
    logic                        ready_s;
    logic                        xfer_s;
    logic [CNT_W-1:0]            burst_len_s;

    // Pick the target voice: lowest idle index first, else the oldest ringing voice.
    always_comb begin
        idle_found_s = 1'b0;
        idle_idx_s   = '0;
        ring_found_s = 1'b0;
        ring_idx_s   = '0;
        ring_age_s   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!idle_found_s && (state_q[v] == ST_IDLE)) begin
                idle_found_s = 1'b1;
                idle_idx_s   = VID_W'(v);
            end else begin
                idle_found_s = idle_found_s;
            end
            // Strict '>' keeps the lowest index on an age tie.
            if ((state_q[v] == ST_RING) && (!ring_found_s || (age_q[v] > ring_age_s))) begin
                ring_found_s = 1'b1;
                ring_idx_s   = VID_W'(v);
                ring_age_s   = age_q[v];
            end else begin
                ring_found_s = ring_found_s;
            end
        end

        if (idle_found_s) begin
            sel_idx_s   = idle_idx_s;
            sel_steal_s = 1'b0;
        end else if (ring_found_s) begin
            sel_idx_s   = ring_idx_s;
            sel_steal_s = 1'b1;
        end else begin
            sel_idx_s   = '0;
            sel_steal_s = 1'b0;
        end

        ready_s     = idle_found_s | ring_found_s;
        xfer_s      = note_valid & ready_s;
        burst_len_s = CNT_W'(calc_eff_len(note_len, note_oct)) << BURST_SHIFT;
    end

    // Per-voice lifetime FSMs, ages and latched configuration for the next cycle.
    always_comb begin
        voice_trig_d = '0;
        voice_len_d  = voice_len_q;
        voice_oct_d  = voice_oct_q;
        voice_busy_d = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            state_d[v] = state_q[v];
            cnt_d[v]   = cnt_q[v];
            age_d[v]   = age_q[v];

            if (xfer_s && (sel_idx_s == VID_W'(v))) begin
                // Allocation beats any expiry on the same cycle.
                state_d[v]                      = ST_EXCITE;
                cnt_d[v]                        = burst_len_s;
                age_d[v]                        = '0;
                voice_trig_d[v]                 = 1'b1;
                voice_len_d[v*LEN_W +: LEN_W]   = note_len;
                voice_oct_d[v*2 +: 2]           = note_oct;
            end else begin
                if (xfer_s && (age_q[v] != AGE_MAX)) begin
                    age_d[v] = age_q[v] + VID_W'(1);
                end else begin
                    age_d[v] = age_q[v];
                end

                // The counter holds the remaining cycles in the phase.
                // The phase ends on the edge that consumes the final cycle.
                case (state_q[v])
                    ST_IDLE: begin
                        state_d[v] = ST_IDLE;
                        cnt_d[v]   = cnt_q[v];
                    end
                    ST_EXCITE: begin
                        if (cnt_q[v] <= CNT_ONE) begin
                            state_d[v] = ST_RING;
                            cnt_d[v]   = CNT_RING;
                        end else begin
                            cnt_d[v]   = cnt_q[v] - CNT_ONE;
                        end
                    end
                    ST_RING: begin
                        if (cnt_q[v] <= CNT_ONE) begin
                            state_d[v] = ST_IDLE;
                            cnt_d[v]   = '0;
                        end else begin
                            cnt_d[v]   = cnt_q[v] - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[v] = ST_IDLE;
                        cnt_d[v]   = '0;
                    end
                endcase
            end

            voice_busy_d[v] = (state_d[v] != ST_IDLE);
        end

        if (xfer_s) begin
            alloc_id_d = sel_idx_s;
            steal_d    = sel_steal_s;
        end else begin
            alloc_id_d = alloc_id_q;
            steal_d    = 1'b0;
        end
    end

    // All state and registered outputs. The asynchronous reset aborts any voice immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= ST_IDLE;
                cnt_q[v]   <= '0;
                age_q[v]   <= '0;
            end
            voice_trig_q <= '0;
            voice_len_q  <= '0;
            voice_oct_q  <= '0;
            voice_busy_q <= '0;
            alloc_id_q   <= '0;
            steal_q      <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= state_d[v];
                cnt_q[v]   <= cnt_d[v];
                age_q[v]   <= age_d[v];
            end
            voice_trig_q <= voice_trig_d;
            voice_len_q  <= voice_len_d;
            voice_oct_q  <= voice_oct_d;
            voice_busy_q <= voice_busy_d;
            alloc_id_q   <= alloc_id_d;
            steal_q      <= steal_d;
        end
    end

    assign note_ready = ready_s;
    assign voice_trig = voice_trig_q;
    assign voice_len  = voice_len_q;
    assign voice_oct  = voice_oct_q;
    assign voice_busy = voice_busy_q;
    assign alloc_id   = alloc_id_q;
    assign steal      = steal_q;

endmodule

// File: tb/tb_pluck_voice_allocator.sv
// Directed bench for pluck_voice_allocator with a trigger scoreboard.
// Each accepted request pushes its expected trigger, and a negedge monitor
// pops and compares the entry when the DUT pulses voice_trig.

module tb_pluck_voice_allocator;

    localparam int NV = 4;
    localparam int LW = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            note_valid;
    logic            note_ready;
    logic [LW-1:0]   note_len;
    logic [1:0]      note_oct;
    logic [NV-1:0]   voice_trig;
    logic [NV*LW-1:0] voice_len;
    logic [NV*2-1:0] voice_oct;
    logic [NV-1:0]   voice_busy;
    logic [1:0]      alloc_id;
    logic            steal;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          voice;
        bit          stl;
        logic [9:0]  len;
        logic [1:0]  oct;
    } exp_t;

    exp_t sb[$];

    pluck_voice_allocator #(
        .NUM_VOICES (NV),
        .LEN_W      (LW),
        .MIN_LEN    (4),
        .BURST_SHIFT(1),
        .RING_CYCLES(100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note_len  (note_len),
        .note_oct  (note_oct),
        .voice_trig(voice_trig),
        .voice_len (voice_len),
        .voice_oct (voice_oct),
        .voice_busy(voice_busy),
        .alloc_id  (alloc_id),
        .steal     (steal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request and hold it until it is accepted. Return the number of
    // cycles that note_ready was low. The task exits 1ns after the accepting edge.
    task automatic send_note(input logic [9:0] len, input logic [1:0] oct,
                             input int exp_v, input bit exp_steal, output int waited);
        exp_t e;
        waited     = 0;
        note_len   = len;
        note_oct   = oct;
        note_valid = 1'b1;
        @(negedge clk);
        while (note_ready !== 1'b1 && waited < 3000) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 3000) check("send_ready_timeout", 32'(note_ready), 32'd1);
        @(posedge clk);
        #1;
        note_valid = 1'b0;
        e.voice = exp_v;
        e.stl   = exp_steal;
        e.len   = len;
        e.oct   = oct;
        sb.push_back(e);
    endtask

    // Wait, with a bound, until every voice is idle. Exit 1ns after a posedge.
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (voice_busy !== 4'b0000 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("wait_idle", 32'(voice_busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Trigger monitor and scoreboard consumer.
    always @(negedge clk) begin
        exp_t e;
        if (voice_trig !== 4'b0000) begin
            if (sb.size() == 0) begin
                check("trig_unexpected", 32'(voice_trig), 32'd0);
            end else begin
                e = sb.pop_front();
                check("mon_trig",     32'(voice_trig), 32'(1) << e.voice);
                check("mon_steal",    32'(steal),      32'(e.stl));
                check("mon_alloc_id", 32'(alloc_id),   32'(e.voice));
                check("mon_len",      32'(voice_len[e.voice*LW +: LW]), 32'(e.len));
                check("mon_oct",      32'(voice_oct[e.voice*2 +: 2]),   32'(e.oct));
            end
        end
    end

    initial begin
        int w;
        note_valid = 1'b0;
        note_len   = '0;
        note_oct   = '0;
        reset      = 1'b0;
        #2 reset   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_trig",  32'(voice_trig), 32'd0);
        check("rst_len",   32'(voice_len),  32'd0);
        check("rst_oct",   32'(voice_oct),  32'd0);
        check("rst_busy",  32'(voice_busy), 32'd0);
        check("rst_alloc", 32'(alloc_id),   32'd0);
        check("rst_steal", 32'(steal),      32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(note_ready), 32'd1);
        @(posedge clk);
        #1;

        // T1: 200/0 -> voice 0, EXCITE 400 + RING 100 cycles
        send_note(10'd200, 2'd0, 0, 1'b0, w);
        check("t1_wait", 32'(w), 32'd0);
        repeat (499) @(posedge clk);
        @(negedge clk);
        check("t1_busy_last_cycle", 32'(voice_busy), 32'h1);
        @(negedge clk);
        check("t1_busy_idle", 32'(voice_busy), 32'h0);
        @(posedge clk);
        #1;

        // T2: four back-to-back requests, then a fifth held off by a full bank
        send_note(10'd100, 2'd0, 0, 1'b0, w); check("t2_wait0", 32'(w), 32'd0);
        send_note(10'd101, 2'd0, 1, 1'b0, w); check("t2_wait1", 32'(w), 32'd0);
        send_note(10'd102, 2'd0, 2, 1'b0, w); check("t2_wait2", 32'(w), 32'd0);
        send_note(10'd103, 2'd0, 3, 1'b0, w); check("t2_wait3", 32'(w), 32'd0);
        send_note(10'd50,  2'd0, 0, 1'b1, w); check("t2_wait_full", 32'(w), 32'd197);

        // T3: all four ringing, allocated 0..3 -> steal voice 0, then voice 1
        wait_idle();
        send_note(10'd4, 2'd0, 0, 1'b0, w);
        send_note(10'd5, 2'd0, 1, 1'b0, w);
        send_note(10'd6, 2'd0, 2, 1'b0, w);
        send_note(10'd7, 2'd0, 3, 1'b0, w);
        repeat (20) @(posedge clk);
        #1;
        send_note(10'd8, 2'd0, 0, 1'b1, w); check("t3_wait_s0", 32'(w), 32'd0);
        send_note(10'd9, 2'd0, 1, 1'b1, w); check("t3_wait_s1", 32'(w), 32'd0);

        // T4: 12>>3 clamps to 4 -> 8-cycle burst; length latched raw
        wait_idle();
        send_note(10'd12,  2'd3, 0, 1'b0, w);
        send_note(10'd500, 2'd0, 1, 1'b0, w);
        send_note(10'd500, 2'd0, 2, 1'b0, w);
        send_note(10'd500, 2'd0, 3, 1'b0, w);
        send_note(10'd500, 2'd0, 0, 1'b1, w); check("t4_wait_clamp", 32'(w), 32'd5);

        // T5: voice 2 is selected on the same edge its ring counter expires
        wait_idle();
        send_note(10'd500, 2'd0, 0, 1'b0, w);
        send_note(10'd500, 2'd0, 1, 1'b0, w);
        send_note(10'd4,   2'd0, 2, 1'b0, w);
        send_note(10'd500, 2'd0, 3, 1'b0, w);
        repeat (106) @(posedge clk);
        #1;
        send_note(10'd500, 2'd0, 2, 1'b1, w); check("t5_wait", 32'(w), 32'd0);
        @(negedge clk);
        check("t5_busy",  32'(voice_busy), 32'hF);
        check("t5_ready", 32'(note_ready), 32'd0);

        // T6: asynchronous reset mid-burst, including during a trigger pulse
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("t6a_busy",  32'(voice_busy), 32'd0);
        check("t6a_ready", 32'(note_ready), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        send_note(10'd300, 2'd0, 0, 1'b0, w);
        send_note(10'd300, 2'd0, 1, 1'b0, w);
        #1 reset = 1'b1;
        #1;
        check("t6b_trig",  32'(voice_trig), 32'd0);
        check("t6b_busy",  32'(voice_busy), 32'd0);
        check("t6b_alloc", 32'(alloc_id),   32'd0);
        check("t6b_len",   32'(voice_len),  32'd0);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        send_note(10'd77, 2'd2, 0, 1'b0, w);
        check("t6_wait", 32'(w), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
